int_scheduler: RTL and testbench
================================

INT_SCHEDULER -- requirements
Module: int_scheduler

Interface
REQ-001 SHALL have one parameter: RANK_RESET, default 4'd8, the ID that is non-maskable and highest priority.
REQ-002 SHALL have CLK, input, 1: the system clock; all state changes on the rising edge.
REQ-003 SHALL have RST, input, 1: the reset; asynchronous and active-high.
REQ-004 SHALL have IRC_ID, input, 4: the interrupt ID presented by the interrupt controller.
REQ-005 SHALL have IRC_ON, input, 1: high while IRC_ID is valid.
REQ-006 SHALL have IRC_ACK, output, 1: a one-cycle capture acknowledge to the interrupt controller.
REQ-007 SHALL have SRC_SET, input, 16: one-cycle pulses from internal sources that set the pending bit of the same index.
REQ-008 SHALL have CFG_WE, input, 1: the configuration write strobe.
REQ-009 SHALL have CFG_ADDR, input, 2: the register select. 0 is MASK_LO, 1 is MASK_HI, 2 is CTRL, 3 is BASE.
REQ-010 SHALL have CFG_WDATA, input, 8: the write data.
REQ-011 SHALL have CFG_RDATA, output, 8: the combinational read of CFG_ADDR.
REQ-012 SHALL have VEC_REQ, output, 1: the vector request to the core.
REQ-013 SHALL have VEC_ADDR, output, 16: the handler address, equal to {BASE, ID, 4'b0000}.
REQ-014 SHALL have VEC_ID, output, 4: the ID being dispatched.
REQ-015 SHALL have VEC_ACK, input, 1: the core accepts the vector.
REQ-016 SHALL have RETI, input, 1: a one-cycle pulse marking the end of the current handler.

Function
REQ-017 SHALL capture IRC_ID into PEND[IRC_ID] and register IRC_ACK=1 on an edge where IRC_ON=1 and IRC_ACK=0; with IRC_ACK=1, no capture occurs.
REQ-018 SHALL OR SRC_SET into PEND each cycle; an IRC capture and a SRC_SET pulse on the same bit give one pending bit.
REQ-019 SHALL treat an ID as eligible when PEND[i]=1, MASK[i]=1 and CTRL.GIE=1; RANK_RESET is eligible whenever it is pending, regardless of MASK and GIE.
REQ-020 SHALL fix priority as RANK_RESET highest, then the remaining IDs with the highest numeric value winning (15 down to 0, skipping 8).
REQ-021 SHALL dispatch the winner only if it ranks strictly above the highest set bit of the in-service bitmap ISR; otherwise the block stays idle.
REQ-022 SHALL use an FSM with two states. IDLE moves to DISPATCH when a winner exists, registering VEC_ID and VEC_ADDR and setting VEC_REQ=1. DISPATCH holds VEC_REQ, VEC_ID and VEC_ADDR stable until VEC_ACK=1, then returns to IDLE.
REQ-023 SHALL, on VEC_ACK in DISPATCH: clear PEND[VEC_ID] unless SRC_SET or a capture sets that bit in the same cycle (set wins), set ISR[VEC_ID], and deassert VEC_REQ on the next edge.
REQ-024 SHALL, on VEC_ACK of RANK_RESET, clear all of PEND and ISR except ISR[RANK_RESET].
REQ-025 SHALL have a latency of 2 edges from IRC_ON sampled high to VEC_REQ high when the ID is eligible and ISR=0.
REQ-026 SHALL, on RETI, clear the highest-ranked set bit of ISR. RETI with ISR=0 SHALL set CTRL.RETI_ERR (bit 7, sticky, write-1-to-clear) and change nothing else.
REQ-027 SHALL let RETI and VEC_ACK in the same cycle take effect together: the RETI clear applies first, then the ISR set.
REQ-028 SHALL not abort an in-progress DISPATCH when MASK or GIE is written, even if the dispatched ID becomes ineligible.
REQ-029 SHALL hold GIE in CTRL bit 0; CTRL bits 6:1 SHALL read 0.
REQ-030 SHALL make a CFG write take effect on the edge; a read in the same cycle SHALL return the old value.

Reset
REQ-031 SHALL, while RST=1, force PEND=0, ISR=0, MASK=16'h0000, GIE=0, RETI_ERR=0, BASE=8'h00, state IDLE, VEC_REQ=0, VEC_ID=0, VEC_ADDR=0 and IRC_ACK=0.
REQ-032 SHALL drop any pending, in-service or dispatching interrupt when RST asserts mid-DISPATCH; VEC_REQ=0 on the first cycle after release.
REQ-033 SHALL leave CFG_RDATA combinational, so it reflects the reset values immediately.

Structure
REQ-034 SHALL take from shared package bf8_int_pkg the ID constants (IRQ=0, RESET=8, DMA_DONE=9, DMA_EXC=10, STK_OVF=11, STK_UNF=12), the CFG address constants, and the FSM state type.
REQ-035 SHALL put the priority selection in one sub-module, int_prio_enc: input a 16-bit vector, output a 4-bit ID and a valid flag, using the rule in REQ-020; it is instanced twice, for the winner and for the ISR top.

Verification
REQ-036 SHALL test: MASK=16'h0080, GIE=1, IRC_ON with ID=7 -> IRC_ACK one cycle; 2 edges later VEC_REQ=1 with VEC_ADDR={BASE,4'h7,4'h0}.
REQ-037 SHALL test: PEND bits 3 and 12 set together, all enabled -> 12 is dispatched first; after VEC_ACK and RETI, 3 is dispatched.
REQ-038 SHALL test: ID 3 in service, SRC_SET[12] -> 12 is dispatched (nested); ID 12 in service, IRC ID=5 -> 5 stays pending until RETI.
REQ-039 SHALL test: GIE=0, MASK=0, IRC ID=8 -> ID 8 is dispatched; after VEC_ACK, PEND=0 and ISR=16'h0100.
REQ-040 SHALL test: RETI with ISR=0 -> CFG_RDATA at addr 2 has bit 7 set; writing 8'h80 clears it.
REQ-041 SHALL test: RST pulsed in DISPATCH -> VEC_REQ=0 asynchronously and all registers at their REQ-031 values.

Source files
------------

// File: rtl/bf8_int_pkg.sv
// Shared IDs, config register map and FSM state type
// for the bf8 interrupt scheduler.
package bf8_int_pkg;

    localparam logic [3:0] ID_IRQ      = 4'd0;
    localparam logic [3:0] ID_RESET    = 4'd8;
    localparam logic [3:0] ID_DMA_DONE = 4'd9;
    localparam logic [3:0] ID_DMA_EXC  = 4'd10;
    localparam logic [3:0] ID_STK_OVF  = 4'd11;
    localparam logic [3:0] ID_STK_UNF  = 4'd12;

    localparam logic [1:0] CFG_MASK_LO = 2'd0;
    localparam logic [1:0] CFG_MASK_HI = 2'd1;
    localparam logic [1:0] CFG_CTRL    = 2'd2;
    localparam logic [1:0] CFG_BASE    = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_DISPATCH
    } state_t;

    // Comparable rank: the non-maskable ID sits above every numeric ID.
    function automatic logic [4:0] rank(
        input logic [3:0] id,
        input logic [3:0] top
    );
        return (id == top) ? 5'd16 : {1'b0, id};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: RANK_RESET first, then the highest
// numeric set bit.
import bf8_int_pkg::*;

module int_prio_enc #(
    parameter logic [3:0] RANK_RESET = ID_RESET
) (
    input  logic [15:0] vec,
    output logic [3:0]  id,
    output logic        valid
);

    always_comb begin
        id    = 4'd0;
        valid = |vec;
        for (int i = 0; i < 16; i++) begin
            if (vec[i] && (4'(i) != RANK_RESET)) begin
                id = 4'(i);
            end
        end
        if (vec[RANK_RESET]) begin
            id = RANK_RESET;
        end
    end

endmodule

// File: rtl/int_scheduler.sv
// Interrupt scheduler: pending/in-service tracking, nested
// priority dispatch and vector handshake to the core.
import bf8_int_pkg::*;

module int_scheduler #(
    parameter logic [3:0] RANK_RESET = ID_RESET
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  IRC_ID,
    input  logic        IRC_ON,
    output logic        IRC_ACK,
    input  logic [15:0] SRC_SET,
    input  logic        CFG_WE,
    input  logic [1:0]  CFG_ADDR,
    input  logic [7:0]  CFG_WDATA,
    output logic [7:0]  CFG_RDATA,
    output logic        VEC_REQ,
    output logic [15:0] VEC_ADDR,
    output logic [3:0]  VEC_ID,
    input  logic        VEC_ACK,
    input  logic        RETI
);

    logic [15:0] pend;
    logic [15:0] isr;
    logic [15:0] mask;
    logic        gie;
    logic        reti_err;
    logic [7:0]  base;
    state_t      state;
    state_t      state_nx;

    logic [15:0] elig;
    logic [15:0] rst_bit;
    logic [3:0]  win_id;
    logic        win_v;
    logic [3:0]  top_id;
    logic        top_v;
    logic        go;
    logic        cap;
    logic        ack_hit;
    logic [15:0] set_v;
    logic [15:0] pend_nx;
    logic [15:0] isr_nx;

    assign rst_bit = 16'h1 << RANK_RESET;
    assign elig    = (pend & (gie ? mask : 16'h0)) | (pend & rst_bit);
    assign cap     = IRC_ON && !IRC_ACK;
    assign set_v   = SRC_SET | (cap ? (16'h1 << IRC_ID) : 16'h0);
    assign ack_hit = (state == S_DISPATCH) && VEC_ACK;
    assign VEC_REQ = (state == S_DISPATCH);

    int_prio_enc #(.RANK_RESET(RANK_RESET)) u_win (
        .vec   (elig),
        .id    (win_id),
        .valid (win_v)
    );

    int_prio_enc #(.RANK_RESET(RANK_RESET)) u_top (
        .vec   (isr),
        .id    (top_id),
        .valid (top_v)
    );

    // Only a strictly higher rank may preempt the handler in service.
    assign go = win_v && (!top_v ||
        (rank(win_id, RANK_RESET) > rank(top_id, RANK_RESET)));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (go) state_nx = S_DISPATCH;
            S_DISPATCH: if (VEC_ACK) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // RETI retires first so a same-cycle accept lands on top of it.
    always_comb begin
        pend_nx = pend;
        isr_nx  = isr;
        if (RETI && top_v) begin
            isr_nx[top_id] = 1'b0;
        end
        if (ack_hit) begin
            if (VEC_ID == RANK_RESET) begin
                pend_nx = 16'h0;
                isr_nx  = rst_bit;
            end else begin
                pend_nx[VEC_ID] = 1'b0;
                isr_nx[VEC_ID]  = 1'b1;
            end
        end
        pend_nx = pend_nx | set_v;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            pend     <= 16'h0;
            isr      <= 16'h0;
            mask     <= 16'h0;
            gie      <= 1'b0;
            reti_err <= 1'b0;
            base     <= 8'h00;
            VEC_ID   <= 4'd0;
            VEC_ADDR <= 16'h0;
            IRC_ACK  <= 1'b0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            isr     <= isr_nx;
            IRC_ACK <= cap;
            if ((state == S_IDLE) && go) begin
                VEC_ID   <= win_id;
                VEC_ADDR <= {base, win_id, 4'h0};
            end
            if (CFG_WE) begin
                unique case (CFG_ADDR)
                    CFG_MASK_LO: mask[7:0]  <= CFG_WDATA;
                    CFG_MASK_HI: mask[15:8] <= CFG_WDATA;
                    CFG_CTRL:    gie        <= CFG_WDATA[0];
                    CFG_BASE:    base       <= CFG_WDATA;
                    default:     ;
                endcase
            end
            if (RETI && !top_v) begin
                reti_err <= 1'b1;
            end else if (CFG_WE && (CFG_ADDR == CFG_CTRL) && CFG_WDATA[7]) begin
                reti_err <= 1'b0;
            end
        end
    end

    always_comb begin
        CFG_RDATA = 8'h00;
        unique case (CFG_ADDR)
            CFG_MASK_LO: CFG_RDATA = mask[7:0];
            CFG_MASK_HI: CFG_RDATA = mask[15:8];
            CFG_CTRL:    CFG_RDATA = {reti_err, 6'b0, gie};
            CFG_BASE:    CFG_RDATA = base;
            default:     CFG_RDATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_int_scheduler.sv
// Bench for int_scheduler: ranked-queue reference model
// compared every cycle, plus directed literal checks.
module tb_int_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  IRC_ID = 4'd0;
    logic        IRC_ON = 1'b0;
    logic        IRC_ACK;
    logic [15:0] SRC_SET = 16'h0;
    logic        CFG_WE = 1'b0;
    logic [1:0]  CFG_ADDR = 2'd0;
    logic [7:0]  CFG_WDATA = 8'h00;
    logic [7:0]  CFG_RDATA;
    logic        VEC_REQ;
    logic [15:0] VEC_ADDR;
    logic [3:0]  VEC_ID;
    logic        VEC_ACK = 1'b0;
    logic        RETI = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    int_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRC_ID    (IRC_ID),
        .IRC_ON    (IRC_ON),
        .IRC_ACK   (IRC_ACK),
        .SRC_SET   (SRC_SET),
        .CFG_WE    (CFG_WE),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_WDATA (CFG_WDATA),
        .CFG_RDATA (CFG_RDATA),
        .VEC_REQ   (VEC_REQ),
        .VEC_ADDR  (VEC_ADDR),
        .VEC_ID    (VEC_ID),
        .VEC_ACK   (VEC_ACK),
        .RETI      (RETI)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [15:0] m_pend = 0, m_isr = 0, m_mask = 0;
    logic        m_gie = 0, m_err = 0, m_busy = 0, m_ack = 0;
    logic [3:0]  m_vid = 0;
    logic [15:0] m_vaddr = 0;
    logic [7:0]  m_base = 0;
    logic        mc;
    logic [15:0] np, ni, el;
    int          w, t;

    function automatic int rnk(input int id);
        return (id == 8) ? 16 : id;
    endfunction

    function automatic int best(input logic [15:0] v);
        int b = -1;
        for (int i = 0; i < 16; i++)
            if (v[i] && (b < 0 || rnk(i) > rnk(b))) b = i;
        return b;
    endfunction

    function automatic logic [7:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask[7:0];
            2'd1:    return m_mask[15:8];
            2'd2:    return {m_err, 6'b0, m_gie};
            default: return m_base;
        endcase
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pend = 0; m_isr = 0; m_mask = 0; m_gie = 0; m_err = 0;
            m_busy = 0; m_ack = 0; m_vid = 0; m_vaddr = 0; m_base = 0;
        end else begin
            mc = IRC_ON && !m_ack;
            np = m_pend;
            ni = m_isr;
            t  = best(m_isr);
            if (CFG_WE && CFG_ADDR == 2'd2 && CFG_WDATA[7]) m_err = 0;
            if (RETI) begin
                if (t < 0) m_err = 1;
                else ni[t] = 1'b0;
            end
            if (m_busy) begin
                if (VEC_ACK) begin
                    if (m_vid == 4'd8) begin
                        np = 0;
                        ni = 16'h0100;
                    end else begin
                        np[m_vid] = 1'b0;
                        ni[m_vid] = 1'b1;
                    end
                    m_busy = 0;
                end
            end else begin
                el = m_pend & (m_gie ? m_mask : 16'h0);
                el[8] = m_pend[8];
                w = best(el);
                if (w >= 0 && (t < 0 || rnk(w) > rnk(t))) begin
                    m_busy  = 1;
                    m_vid   = w[3:0];
                    m_vaddr = {m_base, w[3:0], 4'h0};
                end
            end
            np = np | SRC_SET;
            if (mc) np[IRC_ID] = 1'b1;
            if (CFG_WE) begin
                case (CFG_ADDR)
                    2'd0:    m_mask[7:0] = CFG_WDATA;
                    2'd1:    m_mask[15:8] = CFG_WDATA;
                    2'd2:    m_gie = CFG_WDATA[0];
                    default: m_base = CFG_WDATA;
                endcase
            end
            m_pend = np;
            m_isr  = ni;
            m_ack  = mc;
        end
    end

    always @(posedge CLK) begin
        #1;
        check("irc_ack", IRC_ACK, m_ack);
        check("vec_req", VEC_REQ, m_busy);
        check("vec_id", VEC_ID, m_vid);
        check("vec_addr", VEC_ADDR, m_vaddr);
        check("cfg_rdata", CFG_RDATA, m_rd(CFG_ADDR));
        check("pend", dut.pend, m_pend);
        check("isr", dut.isr, m_isr);
    end

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        CFG_WE = 1; CFG_ADDR = a; CFG_WDATA = d;
        @(negedge CLK);
        CFG_WE = 0;
    endtask

    task automatic src(input logic [15:0] v);
        @(negedge CLK); SRC_SET = v;
        @(negedge CLK); SRC_SET = 0;
    endtask

    task automatic reti_p();
        @(negedge CLK); RETI = 1;
        @(negedge CLK); RETI = 0;
    endtask

    task automatic ack_p();
        @(negedge CLK); VEC_ACK = 1;
        @(negedge CLK); VEC_ACK = 0;
    endtask

    task automatic irc(input logic [3:0] id);
        @(negedge CLK); IRC_ON = 1; IRC_ID = id;
        @(negedge CLK); IRC_ON = 0;
    endtask

    task automatic wait_req(input int id, input string nm);
        int k = 0;
        while (!VEC_REQ && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check(nm, VEC_REQ, 1);
        check({nm, "_id"}, VEC_ID, id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_req", VEC_REQ, 0);
        check("rst_ack", IRC_ACK, 0);
        check("rst_ctrl", CFG_RDATA, 8'h00);
        RST = 0;

        // Latency: capture then vector two edges after IRC_ON
        cfg_wr(2'd0, 8'h80);
        cfg_wr(2'd2, 8'h01);
        cfg_wr(2'd3, 8'hA5);
        @(negedge CLK); IRC_ON = 1; IRC_ID = 4'd7;
        @(negedge CLK); IRC_ON = 0;
        check("lat_irc_ack", IRC_ACK, 1);
        check("lat_req_early", VEC_REQ, 0);
        @(negedge CLK);
        check("lat_req", VEC_REQ, 1);
        check("lat_addr", VEC_ADDR, 16'hA570);
        check("lat_id", VEC_ID, 7);
        check("lat_ack_pulse", IRC_ACK, 0);
        ack_p();
        reti_p();

        // Priority: 12 beats 3; 3 waits for RETI of 12
        cfg_wr(2'd0, 8'hFF);
        cfg_wr(2'd1, 8'hFF);
        src(16'h1008);
        wait_req(12, "prio12");
        ack_p();
        repeat (3) @(negedge CLK);
        check("prio_blocked", VEC_REQ, 0);
        reti_p();
        wait_req(3, "prio3");
        ack_p();
        reti_p();

        // Nesting: 12 preempts 3; 5 held behind 12
        src(16'h0008);
        wait_req(3, "nest3");
        ack_p();
        src(16'h1000);
        wait_req(12, "nest12");
        ack_p();
        irc(4'd5);
        repeat (4) @(negedge CLK);
        check("nest5_held", VEC_REQ, 0);
        check("nest5_pend", dut.pend[5], 1);
        reti_p();
        wait_req(5, "nest5");
        @(negedge CLK); VEC_ACK = 1; RETI = 1;
        @(negedge CLK); VEC_ACK = 0; RETI = 0;
        check("reti_ack_isr", dut.isr, 16'h0020);
        reti_p();
        check("isr_clear", dut.isr, 16'h0000);

        // Non-maskable ID 8 with GIE and MASK off
        cfg_wr(2'd2, 8'h00);
        cfg_wr(2'd0, 8'h00);
        cfg_wr(2'd1, 8'h00);
        irc(4'd8);
        wait_req(8, "nmi");
        check("nmi_addr", VEC_ADDR, 16'hA580);
        ack_p();
        check("nmi_pend", dut.pend, 16'h0000);
        check("nmi_isr", dut.isr, 16'h0100);
        reti_p();

        // Spurious RETI sets sticky error; W1C clears it
        reti_p();
        CFG_ADDR = 2'd2;
        #1 check("reti_err_set", CFG_RDATA, 8'h80);
        @(negedge CLK);
        CFG_WE = 1; CFG_WDATA = 8'h80;
        #1 check("reti_err_old", CFG_RDATA, 8'h80);
        @(negedge CLK); CFG_WE = 0;
        #1 check("reti_err_clr", CFG_RDATA, 8'h00);

        // Asynchronous reset while dispatching
        cfg_wr(2'd2, 8'h01);
        cfg_wr(2'd0, 8'h14);
        cfg_wr(2'd3, 8'h3C);
        src(16'h0014);
        wait_req(4, "rst_disp");
        check("rst_disp_addr", VEC_ADDR, 16'h3C40);
        @(negedge CLK);
        #2 RST = 1;
        #1;
        check("arst_req", VEC_REQ, 0);
        check("arst_id", VEC_ID, 0);
        check("arst_addr", VEC_ADDR, 0);
        check("arst_pend", dut.pend, 0);
        check("arst_isr", dut.isr, 0);
        for (int a = 0; a < 4; a++) begin
            CFG_ADDR = 2'(a);
            #1 check("arst_cfg", CFG_RDATA, 8'h00);
        end
        @(negedge CLK); RST = 0;
        @(negedge CLK);
        check("post_rst_req", VEC_REQ, 0);
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
